avm_led_master: RTL and testbench
=================================

# avm_led_master

Avalon-MM host that drives the LED/GPIO peripheral from the initiator side. Debounces the four push buttons and turns each press into a write of an updated 8-bit LED value. When readback is compiled in, the block then reads the same register back and checks it. It sits in the FPGA fabric beside the HPS bridge, so the LED slave can be exercised without software.

## Interface
- DATA_W, 32: Avalon data width, minimum 8.
- ADDR_W, 4: Avalon address width.
- LED_ADDR, 0: word address of the LED register.
- DEBOUNCE_CYCLES, 50000: number of consecutive stable cycles required to accept a button level.
- TIMEOUT_CYCLES, 1024: maximum cycles one transfer may wait on waitrequest.
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- btn_i  in  4  raw push buttons, active-low, asynchronous
- avm_m0_address  out  ADDR_W  transfer address
- avm_m0_read  out  1  read request
- avm_m0_write  out  1  write request
- avm_m0_writedata  out  DATA_W  write data
- avm_m0_readdata  in  DATA_W  read data, valid in the read accept cycle
- avm_m0_waitrequest  in  1  slave stall
- value_o  out  8  last value accepted by the slave
- busy_o  out  1  a transfer is in progress
- error_o  out  1  sticky fault flag

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer.
- A press event is a one-cycle pulse on the debounced high-to-low transition.
- Commands, computed from value_o as `nxt`:
  - btn0: value+1, wrapping mod 256
  - btn1: value−1, wrapping mod 256
  - btn2: rotate left by 1
  - btn3: nxt = 0x00, and error_o is cleared
- Simultaneous press events: lowest index wins; the others are dropped.
- Press events arriving while busy_o=1 are dropped.
- FSM states: IDLE, WRITE, READ, CHECK.
  - IDLE → WRITE on a press event. Latch nxt; drive address=LED_ADDR and writedata = {zeros, nxt}.
  - WRITE: hold write, address and writedata stable while waitrequest=1.
  - A write is accepted when write=1 and waitrequest=0. On accept, value_o ← nxt and the FSM goes to READ.
  - READ: hold read while waitrequest=1. On accept, capture readdata[7:0] and go to CHECK.
  - CHECK: if the captured byte ≠ value_o, set error_o. Then go to IDLE.
- read and write are never asserted together.
- Timeout: a counter clears on entry to WRITE or READ and increments each stalled cycle. When it reaches TIMEOUT_CYCLES, drop the request, set error_o and go to IDLE. value_o is unchanged if the write timed out.
- error_o is sticky; only reset_n or btn3 clears it.
  - If btn3's own transfer faults, error_o is set again.
- busy_o = (state ≠ IDLE).

## Timing
- Reset values: all avm outputs 0, value_o=0, busy_o=0, error_o=0, FSM in IDLE, debouncers at the released (1) level.
- Button latency: a raw level change produces a press pulse 2 + DEBOUNCE_CYCLES cycles later.
- Press pulse at cycle N → write=1 at N+1.
- With zero wait states:
  - write accepted at N+1
  - read at N+2
  - CHECK at N+3
  - IDLE at N+4
- Each wait-state cycle extends the transfer by one cycle.
- Reset mid-transfer: read and write are 0 after the first clk edge with reset_n=0. The pending command is lost.
- The debouncer counter restarts on every raw change and saturates at DEBOUNCE_CYCLES.

## Configuration
- AVM_READBACK_EN defined: full WRITE → READ → CHECK sequence as described above.
- AVM_READBACK_EN undefined:
  - WRITE accept goes directly to IDLE.
  - avm_m0_read is tied to 0 and readdata is ignored.
  - error_o is set only by timeout.

## Structure
- Package avm_led_pkg holds:
  - the state_t enum {IDLE, WRITE, READ, CHECK}
  - the cmd_t enum {CMD_INC, CMD_DEC, CMD_ROL, CMD_CLR}
  - the default LED_ADDR constant
- One sub-module, btn_debounce (synchronizer, counter and edge pulse), instantiated once per button.
- Command decode, FSM and timeout logic live in the top level.

## Test plan
- No wait states, btn0 pressed twice:
  - writes 0x01 then 0x02 at LED_ADDR
  - each readback matches, error_o=0, value_o=0x02
  - each transfer completes in 4 cycles.
- waitrequest held 3 cycles on the write, btn2 pressed at value_o=0x81:
  - write is held stable with writedata=0x03 for 4 cycles
  - value_o=0x03 after accept.
- Slave returns 0x55 on readback after a write of 0x01: error_o=1. A following btn3 press writes 0x00 and clears error_o.
- waitrequest stuck high for TIMEOUT_CYCLES:
  - write drops, error_o=1, busy_o=0
  - value_o unchanged.
- Raw btn0 bouncing every 10 cycles for 200 cycles, then stable low: exactly one write is issued.
- btn0 and btn1 pressed in the same cycle at value_o=0x00: one write of 0x01. reset_n low during the following READ: read=0 on the next edge and value_o=0.

Source files
------------

// File: rtl/avm_led_pkg.sv
// Shared types and helpers for the Avalon-MM LED host (avm_led_master).
// Holds the FSM state encoding, the button command set and the default
// LED register address.
package avm_led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_INC = 2'd0,
    CMD_DEC = 2'd1,
    CMD_ROL = 2'd2,
    CMD_CLR = 2'd3
  } cmd_t;

  localparam int unsigned LED_ADDR_DEFAULT = 0;

  // New LED byte produced by a command applied to the current value.
  function automatic logic [7:0] apply_cmd(input cmd_t cmd, input logic [7:0] cur);
    case (cmd)
      CMD_INC: apply_cmd = cur + 8'd1;
      CMD_DEC: apply_cmd = cur - 8'd1;
      CMD_ROL: apply_cmd = {cur[6:0], cur[7]};
      default: apply_cmd = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchronizer, stability counter and a
// one-cycle pulse on the accepted high-to-low (press) transition.
// The counter restarts whenever the synchronized level changes and
// saturates at DEBOUNCE_CYCLES; a new level is accepted on the cycle the
// count reaches DEBOUNCE_CYCLES, giving a pulse 2 + DEBOUNCE_CYCLES cycles
// after the raw edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             stable_done;

  // sync1 != sync2 means sync2 is about to take a new level this edge.
  assign stable_done = (sync1 == sync2) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchronize, count stable cycles, accept the level and flag presses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync1 != sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
      if (stable_done && (level != sync2)) begin
        level <= sync2;
        press <= ~sync2;
      end
    end
  end

endmodule

// File: rtl/avm_led_master.sv
// Avalon-MM host for the LED register. Debounced button presses become a
// write of an updated LED byte; with AVM_READBACK_EN defined the register
// is read back and compared, otherwise a write accept ends the transfer.
// Each transfer is bounded by TIMEOUT_CYCLES stalled cycles; faults set
// the sticky error_o, which btn3 (clear command) or reset clears.
module avm_led_master
  import avm_led_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned LED_ADDR        = LED_ADDR_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        btn_i,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  output logic              avm_m0_write,
  output logic [DATA_W-1:0] avm_m0_writedata,
  input  logic [DATA_W-1:0] avm_m0_readdata,
  input  logic              avm_m0_waitrequest,
  output logic [7:0]        value_o,
  output logic              busy_o,
  output logic              error_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic [3:0]       press;
  logic             press_any;
  cmd_t             sel_cmd;
  logic [7:0]       nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             unused_rd;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_i[i]),
      .press   (press[i])
    );
  end

  assign press_any = |press;
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign busy_o    = (state != IDLE);
  assign unused_rd = ^avm_m0_readdata;

  // Pick the lowest-index press and compute the byte it would write.
  always_comb begin
    sel_cmd = CMD_INC;
    if (press[0]) begin
      sel_cmd = CMD_INC;
    end else if (press[1]) begin
      sel_cmd = CMD_DEC;
    end else if (press[2]) begin
      sel_cmd = CMD_ROL;
    end else if (press[3]) begin
      sel_cmd = CMD_CLR;
    end
    nxt = apply_cmd(sel_cmd, value_o);
  end

`ifdef AVM_READBACK_EN
  logic [7:0] rd_byte;
`else
  assign avm_m0_read = 1'b0;
`endif

  // Transfer sequencer: write, optional readback/compare, timeout handling.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      avm_m0_address   <= '0;
      avm_m0_write     <= 1'b0;
      avm_m0_writedata <= '0;
      value_o          <= '0;
      error_o          <= 1'b0;
      tmo_cnt          <= '0;
`ifdef AVM_READBACK_EN
      avm_m0_read      <= 1'b0;
      rd_byte          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (press_any) begin
            state            <= WRITE;
            avm_m0_write     <= 1'b1;
            avm_m0_address   <= ADDR_W'(LED_ADDR);
            avm_m0_writedata <= DATA_W'(nxt);
            tmo_cnt          <= '0;
            if (sel_cmd == CMD_CLR) begin
              error_o <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_write <= 1'b0;
            value_o      <= avm_m0_writedata[7:0];
`ifdef AVM_READBACK_EN
            state        <= READ;
            avm_m0_read  <= 1'b1;
            tmo_cnt      <= '0;
`else
            state        <= IDLE;
`endif
          end else if (tmo_hit) begin
            avm_m0_write <= 1'b0;
            error_o      <= 1'b1;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
`ifdef AVM_READBACK_EN
        READ: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_read <= 1'b0;
            rd_byte     <= avm_m0_readdata[7:0];
            state       <= CHECK;
          end else if (tmo_hit) begin
            avm_m0_read <= 1'b0;
            error_o     <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (rd_byte != value_o) begin
            error_o <= 1'b1;
          end
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avm_led_master.sv
`timescale 1ns/1ps
module tb_avm_led_master;

  localparam int DB  = 16;
  localparam int TMO = 16;
  localparam logic [3:0] LED_A = 4'd5;
`ifdef AVM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  btn_i;
  logic [3:0]  avm_m0_address;
  logic        avm_m0_read;
  logic        avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic [31:0] avm_m0_readdata;
  logic        avm_m0_waitrequest;
  logic [7:0]  value_o;
  logic        busy_o;
  logic        error_o;

  int n_pass  = 0;
  int n_total = 0;

  avm_led_master #(
    .DATA_W          (32),
    .ADDR_W          (4),
    .LED_ADDR        (5),
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .btn_i              (btn_i),
    .avm_m0_address     (avm_m0_address),
    .avm_m0_read        (avm_m0_read),
    .avm_m0_write       (avm_m0_write),
    .avm_m0_writedata   (avm_m0_writedata),
    .avm_m0_readdata    (avm_m0_readdata),
    .avm_m0_waitrequest (avm_m0_waitrequest),
    .value_o            (value_o),
    .busy_o             (busy_o),
    .error_o            (error_o)
  );

  always #5 clk = ~clk;

  // Slave configuration, written only by the test process.
  int         cfg_ws  = 0;
  int         cfg_rs  = 0;
  bit         cfg_bad = 1'b0;
  logic [7:0] cfg_bad_val = 8'h55;

  // Slave state, written only by the slave process.
  logic [31:0] mem = '0;
  int          wr_left = 0, rd_left = 0;
  bit          prev_w = 1'b0, prev_r = 1'b0;
  int          n_wr_acc = 0, wr_high = 0;
  bit          unstable = 1'b0, both_rw = 1'b0;
  logic [31:0] first_wdata = '0, last_acc_wdata = '0;
  logic [3:0]  first_addr = '0;

  // Avalon slave with per-transfer wait states and optional bad readback.
  initial begin
    avm_m0_waitrequest = 1'b0;
    avm_m0_readdata    = '0;
    forever begin
      @(negedge clk);
      if (avm_m0_read && avm_m0_write) both_rw = 1'b1;
      avm_m0_waitrequest = 1'b0;
      if (avm_m0_write) begin
        if (!prev_w) begin
          wr_left = cfg_ws; wr_high = 0; unstable = 1'b0;
          first_wdata = avm_m0_writedata; first_addr = avm_m0_address;
        end else if (avm_m0_writedata !== first_wdata || avm_m0_address !== first_addr) begin
          unstable = 1'b1;
        end
        wr_high++;
        if (wr_left > 0) begin
          avm_m0_waitrequest = 1'b1; wr_left--;
        end else begin
          mem = avm_m0_writedata; last_acc_wdata = avm_m0_writedata; n_wr_acc++;
        end
      end else if (avm_m0_read) begin
        if (!prev_r) rd_left = cfg_rs;
        if (rd_left > 0) begin
          avm_m0_waitrequest = 1'b1; rd_left--;
        end else begin
          avm_m0_readdata = cfg_bad ? {24'h0, cfg_bad_val} : mem;
        end
      end
      prev_w = avm_m0_write;
      prev_r = avm_m0_read;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Hold the buttons in mask low until the transfer finishes, then release.
  task automatic press(input logic [3:0] mask, input int ws, input int rs, input bit bad,
                       input logic [7:0] bad_val, output int lat, output int bcyc);
    cfg_ws = ws; cfg_rs = rs; cfg_bad = bad; cfg_bad_val = bad_val;
    lat = -1; bcyc = 0;
    btn_i = ~mask;
    for (int c = 1; c <= DB + 10; c++) begin
      @(negedge clk);
      if (avm_m0_write) begin lat = c; break; end
    end
    for (int c = 0; c < 4 * TMO && lat > 0; c++) begin
      if (!busy_o) break;
      bcyc++;
      @(negedge clk);
    end
    btn_i = '1;
    repeat (DB + 6) @(negedge clk);
    cfg_ws = 0; cfg_rs = 0; cfg_bad = 1'b0;
  endtask

  function automatic int exp_busy(input int ws, input int rs);
    return RB ? (3 + ws + rs) : (1 + ws);
  endfunction

  typedef struct {
    logic [3:0] mask;
    int         ws;
    int         rs;
    bit         bad;
    logic [7:0] exp_val;
    bit         exp_err;
  } vec_t;

  vec_t vt[20];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, bcyc, acc0, ws, rs, got;
    logic [3:0] mask;
    logic [7:0] mval, nxt, bv;
    bit merr, bad;
    int cmd;

    // value starts at 0x00; expected bytes follow the command arithmetic
    vt[0]  = '{4'b0001, 0, 0, 1'b0, 8'h01, 1'b0};
    vt[1]  = '{4'b0001, 0, 0, 1'b0, 8'h02, 1'b0};
    vt[2]  = '{4'b0001, 0, 2, 1'b0, 8'h03, 1'b0};
    vt[3]  = '{4'b0100, 0, 0, 1'b0, 8'h06, 1'b0};
    vt[4]  = '{4'b0100, 0, 0, 1'b0, 8'h0C, 1'b0};
    vt[5]  = '{4'b0100, 1, 0, 1'b0, 8'h18, 1'b0};
    vt[6]  = '{4'b0100, 0, 0, 1'b0, 8'h30, 1'b0};
    vt[7]  = '{4'b0100, 0, 0, 1'b0, 8'h60, 1'b0};
    vt[8]  = '{4'b0100, 0, 0, 1'b0, 8'hC0, 1'b0};
    vt[9]  = '{4'b0100, 0, 0, 1'b0, 8'h81, 1'b0};
    vt[10] = '{4'b0100, 3, 0, 1'b0, 8'h03, 1'b0};
    vt[11] = '{4'b0010, 0, 0, 1'b0, 8'h02, 1'b0};
    vt[12] = '{4'b1000, 0, 0, 1'b0, 8'h00, 1'b0};
    vt[13] = '{4'b0010, 0, 0, 1'b0, 8'hFF, 1'b0};
    vt[14] = '{4'b0001, 0, 0, 1'b0, 8'h00, 1'b0};
    vt[15] = '{4'b0001, 0, 0, 1'b1, 8'h01, 1'b1};
    vt[16] = '{4'b1000, 0, 0, 1'b0, 8'h00, 1'b0};
    vt[17] = '{4'b0001, 0, 0, 1'b0, 8'h01, 1'b0};
    vt[18] = '{4'b1100, 0, 0, 1'b0, 8'h02, 1'b0};
    vt[19] = '{4'b1110, 0, 1, 1'b0, 8'h01, 1'b0};

    reset_n = 1'b0;
    btn_i   = '1;
    repeat (4) @(negedge clk);
    check("rst_write", avm_m0_write, 0);
    check("rst_read", avm_m0_read, 0);
    check("rst_address", avm_m0_address, 0);
    check("rst_writedata", avm_m0_writedata, 0);
    check("rst_value", value_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_error", error_o, 0);
    reset_n = 1'b1;
    repeat (DB + 4) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      press(vt[i].mask, vt[i].ws, vt[i].rs, vt[i].bad, 8'h55, lat, bcyc);
      check($sformatf("vec%0d_latency", i), lat, DB + 3);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, exp_busy(vt[i].ws, vt[i].rs));
      check($sformatf("vec%0d_wdata", i), last_acc_wdata, {24'h0, vt[i].exp_val});
      check($sformatf("vec%0d_address", i), first_addr, LED_A);
      check($sformatf("vec%0d_stable", i), unstable, 0);
      check($sformatf("vec%0d_write_cycles", i), wr_high, vt[i].ws + 1);
      check($sformatf("vec%0d_value", i), value_o, vt[i].exp_val);
      check($sformatf("vec%0d_error", i), error_o, RB && vt[i].exp_err);
    end
    mval = 8'h01;
    merr = 1'b0;

    // waitrequest stuck high: write must give up after TMO stalled cycles
    acc0 = n_wr_acc;
    press(4'b0001, 1000000, 0, 1'b0, 8'h00, lat, bcyc);
    check("tmo_write_cycles", wr_high, TMO);
    check("tmo_busy_cycles", bcyc, TMO);
    check("tmo_error", error_o, 1);
    check("tmo_busy", busy_o, 0);
    check("tmo_value", value_o, mval);
    check("tmo_no_accept", n_wr_acc - acc0, 0);
    press(4'b1000, 0, 0, 1'b0, 8'h00, lat, bcyc);
    mval = 8'h00;
    check("clr_value", value_o, mval);
    check("clr_error", error_o, 0);

    // bouncing btn0: low/high every 10 cycles for 200 cycles, then held low
    acc0 = n_wr_acc;
    for (int i = 0; i < 20; i++) begin
      btn_i[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (10) @(negedge clk);
    end
    btn_i[0] = 1'b0;
    repeat (DB + 30) @(negedge clk);
    btn_i = '1;
    repeat (DB + 10) @(negedge clk);
    mval = mval + 8'd1;
    check("bounce_one_write", n_wr_acc - acc0, 1);
    check("bounce_value", value_o, mval);

    // randomized presses against the command model
    for (int i = 0; i < 30; i++) begin
      mask = 4'($urandom_range(1, 15));
      ws   = $urandom_range(0, 3);
      rs   = $urandom_range(0, 3);
      bad  = ($urandom_range(0, 3) == 0);
      bv   = 8'($urandom);
      cmd  = 0;
      for (int b = 3; b >= 0; b--) if (mask[b]) cmd = b;
      case (cmd)
        0: nxt = mval + 8'd1;
        1: nxt = mval - 8'd1;
        2: nxt = (mval << 1) | (mval >> 7);
        default: begin nxt = 8'h00; merr = 1'b0; end
      endcase
      if (RB && bad && bv != nxt) merr = 1'b1;
      mval = nxt;
      press(mask, ws, rs, bad, bv, lat, bcyc);
      check($sformatf("rnd%0d_value", i), value_o, mval);
      check($sformatf("rnd%0d_error", i), error_o, merr);
      check($sformatf("rnd%0d_wdata", i), last_acc_wdata, {24'h0, mval});
      check($sformatf("rnd%0d_busy_cycles", i), bcyc, exp_busy(ws, RB ? rs : 0));
    end

    // btn0+btn1 together at value 0, then reset in the middle of the transfer
    press(4'b1000, 0, 0, 1'b0, 8'h00, lat, bcyc);
    check("pre_rst_value", value_o, 0);
    acc0 = n_wr_acc;
    got  = 0;
`ifdef AVM_READBACK_EN
    btn_i = 4'b1100;
    for (int c = 0; c < DB + 10; c++) begin
      @(negedge clk);
      if (avm_m0_read) begin got = 1; break; end
    end
    check("mid_read_reached", got, 1);
    check("mid_single_write", n_wr_acc - acc0, 1);
    check("mid_value", value_o, 1);
`else
    cfg_ws = 3;
    btn_i  = 4'b1100;
    for (int c = 0; c < DB + 10; c++) begin
      @(negedge clk);
      if (avm_m0_write) begin got = 1; break; end
    end
    check("mid_write_reached", got, 1);
    check("mid_value", value_o, 0);
`endif
    check("mid_wdata", avm_m0_writedata, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_read", avm_m0_read, 0);
    check("mid_rst_write", avm_m0_write, 0);
    check("mid_rst_value", value_o, 0);
    check("mid_rst_busy", busy_o, 0);
    btn_i  = '1;
    cfg_ws = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (DB + 6) @(negedge clk);
    check("post_rst_idle", busy_o, 0);
    check("never_read_and_write", both_rw, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
